// File: rtl/vscpu_timer_periph.sv
// Memory-mapped down-counting timer on the VerySimpleCPU RAM bus with one-cycle registered reads.
// Define VSCPU_TMR_IRQ_EN to implement the CTRL.IE bit and drive irq; otherwise irq is tied low.
module vscpu_timer_periph #(
  parameter logic [13:0] BASE_ADDR = 14'h3FF0,
  parameter int unsigned DIV       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] addr,
  input  logic        wrEn,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        sel,
  output logic        irq
);

  localparam logic [15:0] PreMax = 16'(DIV - 1);
`ifdef VSCPU_TMR_IRQ_EN
  localparam logic [2:0] CtrlMask = 3'b111;
`else
  localparam logic [2:0] CtrlMask = 3'b011;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;
  logic [15:0] pre_q, pre_d;
  logic [31:0] dout_q, dout_d;
  logic        sel_q, sel_d;
  logic        irq_q, irq_d;

  logic        hit;
  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick;
  logic [31:0] rdata;

  always_comb begin
    // An X address takes the else branch in simulation, so it never hits.
    hit = 1'b0;
    if (addr[13:2] == BASE_ADDR[13:2]) hit = 1'b1;

    wr_ctrl   = wrEn && hit && (addr[1:0] == 2'd0);
    wr_load   = wrEn && hit && (addr[1:0] == 2'd1);
    wr_count  = wrEn && hit && (addr[1:0] == 2'd2);
    wr_status = wrEn && hit && (addr[1:0] == 2'd3);

    unique case (addr[1:0])
      2'd0:    rdata = {29'd0, ctrl_q};
      2'd1:    rdata = load_q;
      2'd2:    rdata = count_q;
      default: rdata = {31'd0, exp_q};
    endcase

    // A CTRL write that clears EN suppresses a coincident tick.
    tick = (state_q == StRun) && (pre_q == PreMax) && !(wr_ctrl && !data_in[0]);

    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;

    if (wr_status && data_in[0]) exp_d = 1'b0;

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[1] && (load_q != 32'd0)) begin
          count_d = load_q;
        end else begin
          count_d   = 32'd0;
          ctrl_d[0] = 1'b0;
        end
      end
    end

    // Bus writes are applied last so they win over the countdown.
    if (wr_ctrl) ctrl_d = data_in[2:0] & CtrlMask;
    if (wr_load) begin
      load_d  = data_in;
      count_d = data_in;
    end
    if (wr_count) count_d = data_in;

    state_d = ctrl_d[0] ? StRun : StIdle;

    if ((state_q == StIdle) || wr_ctrl || (pre_q == PreMax)) pre_d = 16'd0;
    else                                                       pre_d = pre_q + 16'd1;

    dout_d = hit ? rdata : 32'd0;
    sel_d  = hit;
`ifdef VSCPU_TMR_IRQ_EN
    irq_d  = exp_d & ctrl_d[2];
`else
    irq_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      exp_q   <= 1'b0;
      pre_q   <= 16'd0;
      dout_q  <= 32'd0;
      sel_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      pre_q   <= pre_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      irq_q   <= irq_d;
    end
  end

  assign data_out = dout_q;
  assign sel      = sel_q;
  assign irq      = irq_q;

endmodule

// File: doc/vscpu_timer_periph.md
# vscpu_timer_periph

Memory-mapped down-counting timer that sits on the VerySimpleCPU RAM bus as a second responder next to `blram`. It decodes a 4-word window and answers reads with the same one-cycle registered latency as `blram`. It drives the CPU `interrupt` input when a countdown expires. The top level muxes `data_out` into the CPU's `data_fromRAM` whenever `sel` is high.

## Interface
Parameters:
- `BASE_ADDR`, 14'h3FF0, window base; must be 4-aligned; window is BASE_ADDR..BASE_ADDR+3; must not overlap ISR vector words 14'h14/14'h15.
- `DIV`, 1, prescaler ratio; COUNT decrements once per DIV enabled clocks; legal 1..65535.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  14  CPU `addr_toRAM`.
- `wrEn`  in  1  CPU write strobe.
- `data_in`  in  32  CPU `data_toRAM`.
- `data_out`  out  32  registered read data.
- `sel`  out  1  registered window hit; the top-level mux selects `data_out` when high.
- `irq`  out  1  level interrupt to the CPU `interrupt` input.

## Operation
- Register map, word offset from BASE_ADDR:
  - +0 CTRL[2:0]: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable). Upper bits read 0.
  - +1 LOAD[31:0]: a write sets both LOAD and COUNT.
  - +2 COUNT[31:0]: a write sets COUNT only.
  - +3 STATUS[0]: EXP flag; writing 1 to bit0 clears it; writing 0 has no effect.
- Address decode: full 14-bit equality against the window. An unknown or non-matching address never writes and gives `sel`=0.
- FSM states: IDLE (EN=0) and RUN (EN=1). CTRL writes move between them. RUN returns to IDLE on a one-shot expiry.
- Prescaler `pre` runs 0..DIV-1. Tick = RUN && pre==DIV-1. `pre` clears in IDLE and on any CTRL write.
- On a tick:
  - If COUNT>1: COUNT decrements by 1.
  - If COUNT<=1, this is an expiry: EXP sets to 1.
    - If AUTO=1 and LOAD!=0: COUNT reloads from LOAD and the FSM stays in RUN.
    - Otherwise: COUNT goes to 0 and EN clears (one-shot, back to IDLE).
- `irq` = EXP & IE, driven from flops, with no combinational path from bus inputs.
- The ISR must clear EXP before returning. The CPU re-latches a still-high `interrupt` after return-from-interrupt.

## Timing
- Reset (asynchronous) sets: CTRL=0, LOAD=0, COUNT=0, EXP=0, pre=0, data_out=0, sel=0, irq=0. FSM goes to IDLE.
- A write takes effect at the rising edge where wrEn=1 and addr hits. The new value is readable from the next cycle.
- Read latency is 1 cycle. At each edge, `data_out` takes reg[addr] if hit, else 0, and `sel` takes hit. The CPU samples in its following state, the same as with `blram`.
- One-shot countdown with DIV=1 and LOAD=N>=1: EXP sets at the Nth edge after the edge that wrote EN=1. `irq` rises in the same cycle as EXP.
- Simultaneous events:
  - A bus write to COUNT or LOAD in the same cycle as an expiry: the bus value wins for COUNT; EXP still sets.
  - A W1C to STATUS in the same cycle as a new expiry: the set wins, so EXP=1.
  - A CTRL write clearing EN in the same cycle as a tick: EN=0 wins. No decrement and no expiry happen.
- A read of COUNT in a decrement cycle returns the pre-edge value.
- COUNT never wraps below 0.
- Reset asserted mid-countdown returns everything to reset values immediately, with no clock needed.

## Configuration
- Macro `VSCPU_TMR_IRQ_EN`.
- Defined: IE bit, `irq` output and the behaviour above.
- Undefined:
  - The IE bit is not implemented: it reads 0 and writes are ignored.
  - `irq` is tied to 0.
  - EXP still sets and is still W1C, so software can poll STATUS.

## Test plan
- Reset: assert `rst` mid-run with COUNT=5 and EN=1 → all outputs 0 asynchronously; a read of +2 after reset returns 0.
- One-shot: write LOAD=3, then CTRL=3'b101 (DIV=1) → EXP=1 and irq=1 exactly 3 edges after the CTRL write; CTRL reads 3'b100; COUNT reads 0.
- Auto-reload: LOAD=2, CTRL=3'b011, DIV=4 → EXP sets every 8 clocks and COUNT cycles 2,1,2; irq stays 0 because IE=0.
- W1C/set race: hold irq high, then write STATUS=1 in the same cycle as the next expiry → EXP stays 1; a later write of STATUS=1 alone clears EXP and irq.
- Decode and latency: read BASE_ADDR+1 → data_out=LOAD and sel=1 one cycle later. Read 14'h0014, or an X address → sel=0, data_out=0, and no register changes.
- Config build without VSCPU_TMR_IRQ_EN: run the one-shot scenario → EXP=1, irq stays 0, and CTRL reads 3'b000 after expiry.
